// File: rtl/io_defs_pkg.sv
// Shared constants and FSM state type for the I/O output queue.
package io_defs_pkg;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_OFF_OUT  = 3'd0;
    localparam logic [2:0] IO_OFF_STOP = 3'd4;
    localparam logic [7:0] IO_END_BYTE = 8'h00;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        END,
        HALTED
    } io_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous active-high reset; push when full and pop when
// empty are ignored. rdata_o shows the head entry combinationally.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly log2(DEPTH) bits, so wrap is free for a power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/io_out_queue.sv
// CPU-to-UART byte output queue with program-stop sequencing.
// Define IO_OUT_BYPASS_EN to send bytes straight to the TX register when the queue is empty.
module io_out_queue
    import io_defs_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic [31:0]   cpu_a,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_wr,
    input  logic          io_buffer_full,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    output logic          queue_full,
    output logic [CW-1:0] queue_count,
    output logic          overflow,
    output logic          halted
);

    io_state_e  state_q, state_d;
    logic [7:0] tx_data_q, fifo_head;
    logic       tx_en_q, overflow_q;
    logic       io_sel, port_out, port_stop, wr_ok, out_wr, stop_wr;
    logic       enq, deq, push, bypass, emit_end, fifo_empty;
    logic       unused_a_bits;

    assign unused_a_bits = ^{cpu_a[31:18], cpu_a[15:3]};

    assign io_sel    = (cpu_a[17:16] == IO_SEL);
    assign port_out  = io_sel && (cpu_a[2:0] == IO_OFF_OUT);
    assign port_stop = io_sel && (cpu_a[2:0] == IO_OFF_STOP);
    assign wr_ok     = rdy_in && cpu_wr;

    // Zero bytes are reserved as the stream terminator, so CPU writes of 0x00 are dropped.
    assign out_wr  = wr_ok && port_out && (cpu_dout != IO_END_BYTE) && (state_q == RUN);
    assign stop_wr = wr_ok && port_stop && (state_q == RUN);
    assign enq     = out_wr && !queue_full;
    assign deq     = !fifo_empty && !io_buffer_full;

`ifdef IO_OUT_BYPASS_EN
    assign bypass = enq && fifo_empty && !io_buffer_full;
`else
    assign bypass = 1'b0;
`endif
    assign push     = enq && !bypass;
    assign emit_end = (state_q == END) && !io_buffer_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (push),
        .pop_i   (deq),
        .wdata_i (cpu_dout),
        .rdata_o (fifo_head),
        .full_o  (queue_full),
        .empty_o (fifo_empty),
        .count_o (queue_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (stop_wr) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = END;
            END:     if (!io_buffer_full) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // deq, bypass and emit_end are mutually exclusive: the latter two need an empty queue.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= RUN;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_en_q <= deq || bypass || emit_end;
            if (deq)           tx_data_q <= fifo_head;
            else if (bypass)   tx_data_q <= cpu_dout;
            else if (emit_end) tx_data_q <= IO_END_BYTE;
            if (out_wr && queue_full) overflow_q <= 1'b1;
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign halted   = (state_q == HALTED);

endmodule

// File: doc/io_out_queue.md
Name: io_out_queue

Overview:
- Byte-output queue between the CPU external memory bus (mem_a/mem_dout/mem_wr) and the UART TX path (io_buffer_full back-pressure).
- Captures CPU writes to I/O port 0x30000, buffers them in a FIFO, and drains them to UART whenever TX is not full.
- Handles the 0x30004 program-stop write: drains the queue, emits the terminating 0x00, then latches halted.
- Exports queue_full so the CPU top can stall stores to I/O instead of losing bytes.

Parameters:
- DEPTH, 8, FIFO entries; power of two, min 2.
- CW, $clog2(DEPTH)+1, width of queue_count.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  CPU ready; enqueue gated when low, drain continues
- cpu_a  in  32  CPU address bus (mem_a)
- cpu_dout  in  8  CPU write data (mem_dout)
- cpu_wr  in  1  CPU write strobe, 1 = write (mem_wr)
- io_buffer_full  in  1  UART TX full; no tx_en accepted while high
- tx_data  out  8  byte to UART
- tx_en  out  1  one-cycle strobe; tx_data valid
- queue_full  out  1  count == DEPTH (combinational from registered count)
- queue_count  out  CW  current occupancy
- overflow  out  1  sticky: write arrived while full
- halted  out  1  stop sequence complete; sticky until reset

Behaviour:
- Decode: io_sel = cpu_a[17:16]==2'b11. port_out = io_sel && cpu_a[2:0]==3'd0. port_stop = io_sel && cpu_a[2:0]==3'd4.
- Enqueue condition: rdy_in && cpu_wr && port_out && cpu_dout!=8'h00 && state==RUN && !queue_full. Data 0x00 is ignored silently.
- Write while full (same qualifiers): byte dropped, overflow<=1. Full is evaluated from the registered count, so a same-cycle dequeue does not rescue it.
- Dequeue condition: count!=0 && !io_buffer_full. At the next edge, tx_en=1 and tx_data=head; tx_data and tx_en are registered.
- Latency: a byte enqueued at edge N appears on tx_en at edge N+1 at the earliest.
- Ordering is strict FIFO.
- Count arithmetic: enqueue and dequeue in the same cycle leaves count unchanged. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- State machine:
  - RUN -> DRAIN on a qualified port_stop write (rdy_in && cpu_wr && port_stop). Data is ignored.
  - DRAIN: dequeue continues; all new CPU writes are ignored (no overflow). DRAIN -> END when count==0.
  - END: when !io_buffer_full, drive tx_en=1 and tx_data=8'h00 for one cycle, then -> HALTED.
  - HALTED: halted=1; no tx_en; writes ignored; exit only by reset.
- A stop write landing on the cycle the last byte leaves passes through DRAIN normally. It takes at least one cycle in DRAIN.
- Non-I/O addresses (io_sel=0) and reads (cpu_wr=0) never touch the block.
- rdy_in low: no enqueue and no stop capture; drain and END emission continue.
- Reset (any state, mid-drain included), at the next edge: pointers and count = 0, tx_en=0, tx_data=0, overflow=0, halted=0, state=RUN. Queued bytes are discarded.

Optional Feature:
- Macro: IO_OUT_BYPASS_EN.
- Defined: when count==0, state==RUN, !io_buffer_full, and an enqueue condition holds, the byte skips FIFO storage. tx_en/tx_data are still registered, so it is output at edge N+1 with count unchanged.
  - This is a zero-storage path for the common case: occupancy stays 0 and queue_full never asserts for sparse output.
- Undefined: every byte is written to the FIFO and read out the following cycle. Latency to tx_en is 2 edges when the FIFO starts empty.

Decomposition:
- Shared package io_defs_pkg:
  - IO_SEL = 2'b11
  - IO_OFF_OUT = 3'd0
  - IO_OFF_STOP = 3'd4
  - IO_END_BYTE = 8'h00
  - state enum {RUN, DRAIN, END, HALTED}
- One sub-module: sync_fifo. Parameterised DEPTH/WIDTH, synchronous reset, push/pop/full/empty/count outputs.
- io_out_queue holds the decode, stop FSM and TX register.

Test Plan:
- Write 0x41,0x42,0x43 to 0x30000 on consecutive cycles with io_buffer_full=0 -> tx_en pulses carrying 0x41,0x42,0x43 in order; queue_count returns to 0; overflow=0.
- Hold io_buffer_full=1 and write 9 bytes with DEPTH=8 -> queue_full=1 after the 8th; 9th dropped; overflow=1. Release -> exactly 8 bytes out in order.
- Write 0x00 to 0x30000 and 0x55 to 0x10000 -> no enqueue, no tx_en, count stays 0.
- Queue 3 bytes with TX full, write 0x30004, try writing 0x66 -> 0x66 ignored. Release TX -> 3 bytes, then tx_data=0x00 with tx_en, then halted=1 permanently.
- Assert rst_in while in DRAIN with 4 bytes queued -> next edge: count=0, tx_en=0, halted=0, state RUN. A new write to 0x30000 is accepted.
- With IO_OUT_BYPASS_EN, write 0x7A into an empty queue with TX free -> tx_en with 0x7A at edge N+1; queue_count stays 0 throughout. Without the macro, tx_en comes at N+2.
